loop_stack: RTL and testbench

Parametrised loop-bracket controller for the BeeF processor; it replaces the single-entry loop cache with a DEPTH-deep LIFO of loop-start PCs and a hardware skip counter for zero-entry loops. It sits beside fetch_unit and control_unit. It receives decoded loop opcodes, acc_zero and the incremented PC, and returns a jump target plus a skip indication that the control unit uses to suppress execution. Nesting, overflow and underflow are handled in hardware rather than by memory spills.

---
 rtl/loop_stack_pkg.sv | 18 +
 rtl/loop_lifo.sv | 68 ++++++
 rtl/loop_stack.sv | 156 +++++++++++++++
 tb/tb_loop_stack.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/loop_stack_pkg.sv
// loop_stack_pkg
// Shared definitions for the loop-bracket controller: the decoded loop
// opcode seen from the decoder and the controller state encoding.
package loop_stack_pkg;

  typedef enum logic [1:0] {
    LOOP_NOP   = 2'd0,
    LOOP_OPEN  = 2'd1,
    LOOP_CLOSE = 2'd2
  } loop_op_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SKIP  = 2'd1,
    ERROR = 2'd2
  } loop_state_t;

endpackage

// File: rtl/loop_lifo.sv
// loop_lifo
// DEPTH-entry LIFO of loop-start PCs. The occupancy counter doubles as the
// write pointer; the top entry sits one below it. Storage is not reset, so
// entries are meaningful only below the current count.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-low reset
//   clear          synchronous empty (count -> 0), wins over push/pop
//   push, pop      one operation per cycle; push ignored when full,
//                  pop ignored when empty
//   push_data      value written on push
//   top            entry at the top of the stack (undefined when empty)
//   count          current occupancy, 0..DEPTH
//   full, empty    occupancy status
module loop_lifo #(
  parameter int PC_WIDTH = 8,
  parameter int DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [PC_WIDTH-1:0]      push_data,
  output logic [PC_WIDTH-1:0]      top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] MAX = (AW+1)'(DEPTH);

  logic [PC_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]       top_idx;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  // The read index wraps harmlessly when empty; top is don't-care then.
  assign top_idx = AW'(count - ONE);
  assign top     = mem[top_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + ONE;
    end else if (do_pop) begin
      count <= count - ONE;
    end
  end

  // Storage has no reset so it maps onto plain registers or LUT RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[count[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/loop_stack.sv
// loop_stack
// Loop-bracket controller for the BeeF processor. Tracks nested '[' ... ']'
// loops on a hardware LIFO of loop-start PCs and skips over loops that are
// entered with a zero accumulator using a nesting counter.
//
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-low reset
//   loop_op      decoded bracket opcode (NOP / OPEN / CLOSE)
//   acc_zero     accumulator is zero this cycle
//   pc_in        address following the '[' (pushed as loop start)
//   err_clear    synchronous recovery: empties stack, clears flags, -> RUN
//   jump_valid   fetch loads jump_pc at the coming edge (combinational)
//   jump_pc      loop body start (top of stack)
//   skipping     controller is skipping a zero-entry loop
//   depth        stack occupancy
//   overflow     sticky: push or skip nesting exceeded capacity
//   underflow    sticky: ']' seen with an empty stack
//   error        controller is halted in ERROR
module loop_stack
  import loop_stack_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int DEPTH      = 16,
  parameter int SKIP_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  loop_op_t                loop_op,
  input  logic                    acc_zero,
  input  logic [PC_WIDTH-1:0]     pc_in,
  input  logic                    err_clear,
  output logic                    jump_valid,
  output logic [PC_WIDTH-1:0]     jump_pc,
  output logic                    skipping,
  output logic [$clog2(DEPTH):0]  depth,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    error
);

  localparam logic [SKIP_WIDTH-1:0] SKIP_ONE = SKIP_WIDTH'(1);

  loop_state_t           state, state_nxt;
  logic [SKIP_WIDTH-1:0] skip_cnt, skip_cnt_nxt;
  logic                  overflow_nxt, underflow_nxt;
  logic                  push, pop, clear;
  logic                  full, empty;

  loop_lifo #(
    .PC_WIDTH (PC_WIDTH),
    .DEPTH    (DEPTH)
  ) u_lifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .push_data (pc_in),
    .top       (jump_pc),
    .count     (depth),
    .full      (full),
    .empty     (empty)
  );

  assign skipping = (state == SKIP);
  assign error    = (state == ERROR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      skip_cnt  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      skip_cnt  <= skip_cnt_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

  // err_clear takes priority and swallows the opcode of its cycle. A ']'
  // with a non-zero accumulator only redirects fetch; the stack entry stays
  // until the loop finally falls through with acc_zero.
  always_comb begin
    state_nxt     = state;
    skip_cnt_nxt  = skip_cnt;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    push          = 1'b0;
    pop           = 1'b0;
    clear         = 1'b0;
    jump_valid    = 1'b0;

    if (err_clear) begin
      clear         = 1'b1;
      state_nxt     = RUN;
      skip_cnt_nxt  = '0;
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
    end else begin
      case (state)
        RUN: begin
          case (loop_op)
            LOOP_OPEN: begin
              if (acc_zero) begin
                state_nxt    = SKIP;
                skip_cnt_nxt = SKIP_ONE;
              end else if (full) begin
                overflow_nxt = 1'b1;
                state_nxt    = ERROR;
              end else begin
                push = 1'b1;
              end
            end
            LOOP_CLOSE: begin
              if (empty) begin
                underflow_nxt = 1'b1;
                state_nxt     = ERROR;
              end else if (acc_zero) begin
                pop = 1'b1;
              end else begin
                jump_valid = 1'b1;
              end
            end
            default: ;
          endcase
        end
        SKIP: begin
          case (loop_op)
            LOOP_OPEN: begin
              if (skip_cnt == '1) begin
                overflow_nxt = 1'b1;
                state_nxt    = ERROR;
              end else begin
                skip_cnt_nxt = skip_cnt + SKIP_ONE;
              end
            end
            LOOP_CLOSE: begin
              if (skip_cnt == SKIP_ONE) begin
                state_nxt    = RUN;
                skip_cnt_nxt = '0;
              end else begin
                skip_cnt_nxt = skip_cnt - SKIP_ONE;
              end
            end
            default: ;
          endcase
        end
        ERROR: ;
        default: state_nxt = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_loop_stack.sv
// tb_loop_stack
// Directed bench for loop_stack with a 4-deep stack and a 2-bit skip
// counter so both capacity limits are reachable in a few cycles.
module tb_loop_stack;
  import loop_stack_pkg::*;

  logic           clk;
  logic           reset;
  loop_op_t       loop_op;
  logic           acc_zero;
  logic [7:0]     pc_in;
  logic           err_clear;
  logic           jump_valid;
  logic [7:0]     jump_pc;
  logic           skipping;
  logic [2:0]     depth;
  logic           overflow;
  logic           underflow;
  logic           error;

  int compared   = 0;
  int mismatched = 0;

  loop_stack #(
    .PC_WIDTH   (8),
    .DEPTH      (4),
    .SKIP_WIDTH (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .loop_op    (loop_op),
    .acc_zero   (acc_zero),
    .pc_in      (pc_in),
    .err_clear  (err_clear),
    .jump_valid (jump_valid),
    .jump_pc    (jump_pc),
    .skipping   (skipping),
    .depth      (depth),
    .overflow   (overflow),
    .underflow  (underflow),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 ns after a rising edge; combinational outputs are
  // sampled 1 ns later, well away from the next edge.
  task automatic apply_stimulus(input loop_op_t op, input logic az,
                                input logic [7:0] pc, input logic clr);
    loop_op   = op;
    acc_zero  = az;
    pc_in     = pc;
    err_clear = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    loop_op   = LOOP_NOP;
    acc_zero  = 1'b0;
    pc_in     = 8'h00;
    err_clear = 1'b0;
    #3;
    check_output("rst_depth", 32'(depth), 0);
    check_output("rst_jump", 32'(jump_valid), 0);
    check_output("rst_skip", 32'(skipping), 0);
    check_output("rst_err", 32'(error), 0);
    check_output("rst_flags", {30'd0, overflow, underflow}, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Simple loop
    apply_stimulus(LOOP_OPEN, 1'b0, 8'h05, 1'b0);
    check_output("s_open_nojump", 32'(jump_valid), 0);
    tick();
    check_output("s_depth1", 32'(depth), 1);
    apply_stimulus(LOOP_CLOSE, 1'b0, 8'h00, 1'b0);
    check_output("s_close_jv", 32'(jump_valid), 1);
    check_output("s_close_pc", 32'(jump_pc), 32'h05);
    tick();
    check_output("s_depth_hold", 32'(depth), 1);
    apply_stimulus(LOOP_CLOSE, 1'b1, 8'h00, 1'b0);
    check_output("s_exit_jv", 32'(jump_valid), 0);
    tick();
    check_output("s_depth0", 32'(depth), 0);

    // Nesting
    apply_stimulus(LOOP_OPEN, 1'b0, 8'h03, 1'b0);
    tick();
    apply_stimulus(LOOP_OPEN, 1'b0, 8'h07, 1'b0);
    tick();
    check_output("n_depth2", 32'(depth), 2);
    apply_stimulus(LOOP_CLOSE, 1'b0, 8'h00, 1'b0);
    check_output("n_inner_jv", 32'(jump_valid), 1);
    check_output("n_inner_pc", 32'(jump_pc), 32'h07);
    tick();
    apply_stimulus(LOOP_CLOSE, 1'b1, 8'h00, 1'b0);
    check_output("n_pop_jv", 32'(jump_valid), 0);
    tick();
    check_output("n_depth1", 32'(depth), 1);
    apply_stimulus(LOOP_CLOSE, 1'b0, 8'h00, 1'b0);
    check_output("n_outer_jv", 32'(jump_valid), 1);
    check_output("n_outer_pc", 32'(jump_pc), 32'h03);
    tick();
    apply_stimulus(LOOP_CLOSE, 1'b1, 8'h00, 1'b0);
    tick();
    check_output("n_depth0", 32'(depth), 0);

    // Skip a zero-entry loop containing a nested loop
    apply_stimulus(LOOP_OPEN, 1'b1, 8'h40, 1'b0);
    check_output("k_pre_skip", 32'(skipping), 0);
    tick();
    check_output("k_skip1", 32'(skipping), 1);
    apply_stimulus(LOOP_OPEN, 1'b0, 8'h41, 1'b0);
    check_output("k_open_jv", 32'(jump_valid), 0);
    tick();
    check_output("k_skip2", 32'(skipping), 1);
    check_output("k_depth_a", 32'(depth), 0);
    apply_stimulus(LOOP_CLOSE, 1'b0, 8'h00, 1'b0);
    check_output("k_close_jv", 32'(jump_valid), 0);
    tick();
    check_output("k_skip3", 32'(skipping), 1);
    apply_stimulus(LOOP_CLOSE, 1'b0, 8'h00, 1'b0);
    check_output("k_close2_jv", 32'(jump_valid), 0);
    tick();
    check_output("k_run", 32'(skipping), 0);
    check_output("k_depth_b", 32'(depth), 0);
    check_output("k_no_err", 32'(error), 0);

    // Skip nesting counter saturates at 3 with a 2-bit counter
    apply_stimulus(LOOP_OPEN, 1'b1, 8'h00, 1'b0);
    tick();
    apply_stimulus(LOOP_OPEN, 1'b0, 8'h00, 1'b0);
    tick();
    apply_stimulus(LOOP_OPEN, 1'b0, 8'h00, 1'b0);
    tick();
    check_output("ks_at_max", {30'd0, skipping, error}, 32'b10);
    apply_stimulus(LOOP_OPEN, 1'b0, 8'h00, 1'b0);
    tick();
    check_output("ks_err", 32'(error), 1);
    check_output("ks_ovf", 32'(overflow), 1);
    check_output("ks_noskip", 32'(skipping), 0);
    apply_stimulus(LOOP_NOP, 1'b0, 8'h00, 1'b1);
    tick();
    check_output("ks_clr", {29'd0, error, overflow, underflow}, 0);

    // Stack overflow
    apply_stimulus(LOOP_OPEN, 1'b0, 8'h10, 1'b0);
    tick();
    apply_stimulus(LOOP_OPEN, 1'b0, 8'h11, 1'b0);
    tick();
    apply_stimulus(LOOP_OPEN, 1'b0, 8'h12, 1'b0);
    tick();
    apply_stimulus(LOOP_OPEN, 1'b0, 8'h13, 1'b0);
    tick();
    check_output("o_full", 32'(depth), 4);
    check_output("o_no_err", 32'(error), 0);
    apply_stimulus(LOOP_OPEN, 1'b0, 8'h14, 1'b0);
    tick();
    check_output("o_depth", 32'(depth), 4);
    check_output("o_ovf", 32'(overflow), 1);
    check_output("o_err", 32'(error), 1);
    check_output("o_top", 32'(jump_pc), 32'h13);
    apply_stimulus(LOOP_CLOSE, 1'b0, 8'h00, 1'b0);
    check_output("o_close_jv", 32'(jump_valid), 0);
    tick();
    check_output("o_err_hold", 32'(error), 1);
    apply_stimulus(LOOP_OPEN, 1'b0, 8'h15, 1'b1);
    tick();
    check_output("o_clr_depth", 32'(depth), 0);
    check_output("o_clr_flags", {29'd0, error, overflow, underflow}, 0);

    // Underflow from empty stack
    apply_stimulus(LOOP_CLOSE, 1'b0, 8'h00, 1'b0);
    check_output("u_jv", 32'(jump_valid), 0);
    tick();
    check_output("u_unf", 32'(underflow), 1);
    check_output("u_err", 32'(error), 1);
    check_output("u_ovf", 32'(overflow), 0);
    apply_stimulus(LOOP_NOP, 1'b0, 8'h00, 1'b1);
    tick();
    check_output("u_clr", {29'd0, error, overflow, underflow}, 0);

    // Asynchronous reset while skipping with skip_cnt = 3
    apply_stimulus(LOOP_OPEN, 1'b0, 8'h20, 1'b0);
    tick();
    apply_stimulus(LOOP_OPEN, 1'b1, 8'h00, 1'b0);
    tick();
    apply_stimulus(LOOP_OPEN, 1'b0, 8'h00, 1'b0);
    tick();
    apply_stimulus(LOOP_OPEN, 1'b0, 8'h00, 1'b0);
    tick();
    apply_stimulus(LOOP_NOP, 1'b0, 8'h00, 1'b0);
    check_output("r_pre_skip", 32'(skipping), 1);
    check_output("r_pre_depth", 32'(depth), 1);
    #2;
    reset = 1'b0;
    #1;
    check_output("r_skip", 32'(skipping), 0);
    check_output("r_depth", 32'(depth), 0);
    check_output("r_err", {29'd0, error, overflow, underflow}, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    apply_stimulus(LOOP_OPEN, 1'b0, 8'h2a, 1'b0);
    tick();
    check_output("r_push_depth", 32'(depth), 1);
    apply_stimulus(LOOP_CLOSE, 1'b0, 8'h00, 1'b0);
    check_output("r_jv", 32'(jump_valid), 1);
    check_output("r_pc", 32'(jump_pc), 32'h2a);
    tick();

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
